// File: rtl/uart_pkg.sv
// Shared UART definitions: serializer state encoding, frame constants and
// the clocks-per-bit derivation used by the transmitter and receiver.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int DATA_BITS = 8;

  function automatic int clksPerBit(input int clkFreq, input int baud);
    return clkFreq / baud;
  endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
// Synchronous byte FIFO with registered read data (valid the cycle after
// rd_en). Pushes while full and pops while empty are ignored.
module uart_byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [7:0]                 wr_data,
  input  logic                       rd_en,
  output logic [7:0]                 rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wrPtr_q;
  logic [PTR_W-1:0] rdPtr_q;
  logic [CNT_W-1:0] count_q;
  logic [7:0]       rdData_q;
  logic             doPush;
  logic             doPop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign doPush  = wr_en && !full;
  assign doPop   = rd_en && !empty;
  assign count   = count_q;
  assign rd_data = rdData_q;

  always_ff @(posedge clk) begin
    if (doPush) begin
      mem[wrPtr_q] <= wr_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q  <= '0;
      rdPtr_q  <= '0;
      count_q  <= '0;
      rdData_q <= '0;
    end else begin
      if (doPush) begin
        wrPtr_q <= wrPtr_q + PTR_W'(1);
      end
      if (doPop) begin
        rdPtr_q  <= rdPtr_q + PTR_W'(1);
        rdData_q <= mem[rdPtr_q];
      end
      if (doPush && !doPop) begin
        count_q <= count_q + CNT_W'(1);
      end else if (doPop && !doPush) begin
        count_q <= count_q - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: bytes enter a FIFO on a valid/ready stream
// and are serialized LSB-first with back-to-back frames when data is queued.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  input  logic [7:0]                      in_data,
  output logic                            in_ready,
  output logic                            tx,
  output logic                            busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count
);

  localparam int CLKS_PER_BIT = clksPerBit(CLK_FREQ, BAUD);
  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  uart_state_e       state_q, state_d;
  logic [BAUD_W-1:0] baudCnt_q, baudCnt_d;
  logic [2:0]        bitIdx_q, bitIdx_d;
  logic [7:0]        shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              baudDone;
  logic              popEn;
  logic              fifoFull;
  logic              fifoEmpty;
  logic [7:0]        fifoRdData;

  uart_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (in_valid),
    .wr_data (in_data),
    .rd_en   (popEn),
    .rd_data (fifoRdData),
    .full    (fifoFull),
    .empty   (fifoEmpty),
    .count   (fifo_count)
  );

  assign in_ready = !fifoFull;
  assign tx       = tx_q;
  assign busy     = (state_q != IDLE) || (fifo_count != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      baudCnt_q <= '0;
      bitIdx_q  <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      baudCnt_q <= baudCnt_d;
      bitIdx_q  <= bitIdx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
    end
  end

  // The popped byte lands in the FIFO read register one cycle after the pop,
  // so it is captured into the shift register as START hands over to DATA.
  always_comb begin
    state_d   = state_q;
    baudCnt_d = baudCnt_q;
    bitIdx_d  = bitIdx_q;
    shift_d   = shift_q;
    popEn     = 1'b0;
    baudDone  = (baudCnt_q == BAUD_LAST);

    case (state_q)
      IDLE: begin
        if (!fifoEmpty) begin
          popEn     = 1'b1;
          state_d   = START;
          baudCnt_d = '0;
        end
      end
      START: begin
        if (baudDone) begin
          state_d   = DATA;
          baudCnt_d = '0;
          bitIdx_d  = '0;
          shift_d   = fifoRdData;
        end else begin
          baudCnt_d = baudCnt_q + BAUD_W'(1);
        end
      end
      DATA: begin
        if (baudDone) begin
          baudCnt_d = '0;
          shift_d   = {1'b0, shift_q[7:1]};
          if (bitIdx_q == LAST_BIT) begin
            state_d = STOP;
          end else begin
            bitIdx_d = bitIdx_q + 3'd1;
          end
        end else begin
          baudCnt_d = baudCnt_q + BAUD_W'(1);
        end
      end
      STOP: begin
        if (baudDone) begin
          baudCnt_d = '0;
          if (!fifoEmpty) begin
            popEn   = 1'b1;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baudCnt_d = baudCnt_q + BAUD_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Scoreboard bench for uart_tx_buffered: accepted bytes are queued as
// expectations and a line monitor decodes frames from tx and compares them.
module tb_uart_tx_buffered;

  localparam int CLK_FREQ   = 400;
  localparam int BAUD       = 100;
  localparam int FIFO_DEPTH = 4;
  localparam int CPB        = CLK_FREQ / BAUD;
  localparam int FRAME      = 10 * CPB;
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
  localparam int ACC_LIMIT  = 2 * FRAME + 10;
  localparam int IDLE_LIMIT = (FIFO_DEPTH + 2) * FRAME + 20;

  logic             clk      = 1'b0;
  logic             rst_n    = 1'b1;
  logic             in_valid = 1'b0;
  logic [7:0]       in_data  = 8'h00;
  logic             in_ready;
  logic             tx;
  logic             busy;
  logic [CNT_W-1:0] fifo_count;

  uart_tx_buffered #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD       (BAUD),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .tx         (tx),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  int         checks    = 0;
  int         fails     = 0;
  logic [7:0] expQ[$];
  logic [7:0] stimQ[$];
  int         acceptCnt = 0;
  int         startCnt  = 0;
  bit         inFrame   = 1'b0;
  bit         mustStart = 1'b0;
  int         sIdx      = 0;
  logic       segVal [10];
  bit         glitch    = 1'b0;
  int         peakCount = 0;

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      if (fails <= 40)
        $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                 name, act, act, exp, exp, $time);
    end
  endtask

  // Drives each byte of stimQ, holding it until accepted; an accept is known
  // at the negedge before the edge (in_ready only changes on clock edges).
  task automatic applyStimulus(input int maxGap);
    for (int i = 0; i < stimQ.size(); i++) begin
      int  gap;
      int  guard;
      bit  acc;
      gap = (maxGap > 0) ? $urandom_range(0, maxGap) : 0;
      repeat (gap) begin
        @(negedge clk);
        in_valid = 1'b0;
      end
      guard = 0;
      acc   = 1'b0;
      while (!acc && guard < ACC_LIMIT) begin
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = stimQ[i];
        acc      = in_ready;
        @(posedge clk);
        guard++;
      end
      if (acc) begin
        expQ.push_back(stimQ[i]);
        acceptCnt++;
      end else begin
        checkOutput("accept_timeout", guard, 0);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while ((expQ.size() != 0 || inFrame || busy) && n < IDLE_LIMIT) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain_timeout", int'(n < IDLE_LIMIT), 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic finishFrame();
    logic [7:0] rxByte;
    for (int b = 0; b < 8; b++) rxByte[b] = segVal[b + 1];
    checkOutput("frame_shape", {glitch, segVal[0], segVal[9]}, 3'b001);
    checkOutput("frame_expected", int'(expQ.size() != 0), 1);
    if (expQ.size() != 0) checkOutput("rx_byte", rxByte, expQ.pop_front());
  endtask

  // Line monitor: one sample per cycle; a frame is 10 constant segments of
  // CPB samples, and a queued byte must start on the very next sample.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        inFrame   = 1'b0;
        mustStart = 1'b0;
        sIdx      = 0;
        startCnt  = 0;
        glitch    = 1'b0;
        checkOutput("reset_tx", tx, 1);
        checkOutput("reset_count", fifo_count, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_in_ready", in_ready, 1);
      end else begin
        int pending;
        int slot;
        bit sampled;
        sampled = 1'b0;
        if (!inFrame) begin
          if (tx == 1'b0) begin
            inFrame = 1'b1;
            sIdx    = 0;
            glitch  = 1'b0;
            startCnt++;
          end else if (mustStart) begin
            checkOutput("start_latency", tx, 0);
          end
        end
        if (inFrame) begin
          sampled = 1'b1;
          slot = sIdx / CPB;
          if (sIdx % CPB == 0) segVal[slot] = tx;
          else if (tx !== segVal[slot]) glitch = 1'b1;
          sIdx++;
          if (sIdx == FRAME) begin
            inFrame = 1'b0;
            finishFrame();
          end
        end
        pending   = acceptCnt - startCnt;
        mustStart = !inFrame && (pending > 0);
        checkOutput("fifo_count", fifo_count, pending);
        checkOutput("in_ready", in_ready, int'(pending < FIFO_DEPTH));
        checkOutput("busy", busy, int'(sampled || pending != 0));
        if (int'(fifo_count) > peakCount) peakCount = fifo_count;
      end
    end
  end

  initial begin
    int n;
    #1 rst_n = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (100) @(negedge clk);

    $display("[TB] single byte 0x55");
    stimQ = {8'h55};
    applyStimulus(0);
    waitIdle();

    $display("[TB] burst 0x00 0xFF 0xA5");
    peakCount = 0;
    stimQ = {8'h00, 8'hFF, 8'hA5};
    applyStimulus(0);
    waitIdle();
    checkOutput("burst_peak", peakCount, 2);

    $display("[TB] overflow 0x01..0x08");
    peakCount = 0;
    stimQ.delete();
    for (int v = 1; v <= 8; v++) stimQ.push_back(8'(v));
    applyStimulus(0);
    waitIdle();
    checkOutput("overflow_peak", peakCount, FIFO_DEPTH);

    $display("[TB] reset mid-frame");
    stimQ = {8'h3C, 8'h11, 8'h22};
    applyStimulus(0);
    n = 0;
    while (!(inFrame && (sIdx / CPB) == 4) && n < 200) begin
      @(posedge clk);
      n++;
    end
    checkOutput("reach_bit3", int'(n < 200), 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_rst_tx", tx, 1);
    checkOutput("async_rst_count", fifo_count, 0);
    expQ.delete();
    acceptCnt = 0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (3 * FRAME) @(negedge clk);
    checkOutput("post_reset_busy", busy, 0);

    $display("[TB] random bytes with random gaps");
    stimQ.delete();
    repeat (40) stimQ.push_back(8'($urandom));
    applyStimulus(60);
    waitIdle();

    $display("[TB] sweep 0x00..0xFF");
    stimQ.delete();
    for (int v = 0; v < 256; v++) stimQ.push_back(8'(v));
    applyStimulus(0);
    waitIdle();
    checkOutput("scoreboard_empty", expQ.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
